// File: rtl/matrix_output.sv
// matrix_output: serialises a snapshotted matrix into ASCII bytes for uart_tx.
// Each row is sent as hex digits separated by spaces and terminated by CR LF.
// Illegal dimensions end the frame at once with done and err and no bytes.
// Optional build macro: MATRIX_OUT_HEADER_EN prepends "m x n CR LF" to the body.
module matrix_output #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [3:0]                        mat_m,
    input  logic [3:0]                        mat_n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_data,
    input  logic                              tx_busy,
    output logic [7:0]                        tx_data,
    output logic                              tx_start,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int DATA_W = MAX_DIM * MAX_DIM * ELEM_W;

    // ST_FIN is only ever a return target of ST_WAIT: it marks "last LF sent".
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
`ifdef MATRIX_OUT_HEADER_EN
        ST_HDR  = 4'd1,
`endif
        ST_ELEM = 4'd2,
        ST_SEP  = 4'd3,
        ST_CR   = 4'd4,
        ST_LF   = 4'd5,
        ST_WAIT = 4'd6,
        ST_FIN  = 4'd7
    } state_e;

`ifdef MATRIX_OUT_HEADER_EN
    localparam state_e FIRST_ST = ST_HDR;
`else
    localparam state_e FIRST_ST = ST_ELEM;
`endif

    // One hex digit to its upper-case ASCII code.
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        logic [7:0] r;
        if (v < 4'd10) begin
            r = 8'h30 + {4'h0, v};
        end else begin
            r = 8'h37 + {4'h0, v};
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [1:0]         wait_q, wait_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         m_q, m_d;
    logic [3:0]         n_q, n_d;
    logic [DATA_W-1:0]  mat_q, mat_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef MATRIX_OUT_HEADER_EN
    logic [2:0]         hdr_q, hdr_d;
    logic [7:0]         hdr_byte_s;
`endif

    int                 elem_base_s;
    logic [ELEM_W-1:0]  elem_s;
    logic               dims_bad_s;
    logic               last_col_s;
    logic               last_row_s;

    assign elem_base_s = (int'(row_q) * MAX_DIM + int'(col_q)) * ELEM_W;
    assign elem_s      = mat_q[elem_base_s +: ELEM_W];
    assign dims_bad_s  = (mat_m == 4'd0) || (mat_m > 4'(MAX_DIM)) ||
                         (mat_n == 4'd0) || (mat_n > 4'(MAX_DIM));
    assign last_col_s  = (col_q == (n_q - 4'd1));
    assign last_row_s  = (row_q == (m_q - 4'd1));

`ifdef MATRIX_OUT_HEADER_EN
    // Header byte selected by the header index: m, 'x', n, CR, LF.
    always_comb begin
        case (hdr_q)
            3'd0:    hdr_byte_s = hex_ascii(m_q);
            3'd1:    hdr_byte_s = 8'h78;
            3'd2:    hdr_byte_s = hex_ascii(n_q);
            3'd3:    hdr_byte_s = 8'h0D;
            default: hdr_byte_s = 8'h0A;
        endcase
    end
`endif

    // Next-state logic; every byte launch is followed by ST_WAIT.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        wait_d     = wait_q;
        row_d      = row_q;
        col_d      = col_q;
        m_d        = m_q;
        n_d        = n_q;
        mat_d      = mat_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef MATRIX_OUT_HEADER_EN
        hdr_d      = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Dimensions are judged on the inputs being snapshotted, so a bad
                // frame reports done/err in the cycle right after start.
                if (start) begin
                    m_d   = mat_m;
                    n_d   = mat_n;
                    mat_d = mat_data;
                    row_d = 4'd0;
                    col_d = 4'd0;
`ifdef MATRIX_OUT_HEADER_EN
                    hdr_d = 3'd0;
`endif
                    if (dims_bad_s) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = FIRST_ST;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
`ifdef MATRIX_OUT_HEADER_EN
            ST_HDR: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = hdr_byte_s;
                    hdr_d      = hdr_q + 3'd1;
                    ret_d      = (hdr_q == 3'd4) ? ST_ELEM : ST_HDR;
                    wait_d     = 2'd0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_ELEM: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = hex_ascii(elem_s[3:0]);
                    ret_d      = last_col_s ? ST_CR : ST_SEP;
                    wait_d     = 2'd0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_ELEM;
                end
            end
            ST_SEP: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h20;
                    col_d      = col_q + 4'd1;
                    ret_d      = ST_ELEM;
                    wait_d     = 2'd0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_SEP;
                end
            end
            ST_CR: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h0D;
                    ret_d      = ST_LF;
                    wait_d     = 2'd0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_CR;
                end
            end
            ST_LF: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h0A;
                    col_d      = 4'd0;
                    wait_d     = 2'd0;
                    state_d    = ST_WAIT;
                    if (last_row_s) begin
                        ret_d = ST_FIN;
                    end else begin
                        row_d = row_q + 4'd1;
                        ret_d = ST_ELEM;
                    end
                end else begin
                    state_d = ST_LF;
                end
            end
            ST_WAIT: begin
                // Two cycles let uart_tx raise tx_busy before it is trusted.
                if (wait_q != 2'd2) begin
                    wait_d = wait_q + 2'd1;
                end else if (!tx_busy) begin
                    if (ret_q == ST_FIN) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ret_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset that aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            wait_q     <= 2'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            m_q        <= 4'd0;
            n_q        <= 4'd0;
            mat_q      <= {DATA_W{1'b0}};
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MATRIX_OUT_HEADER_EN
            hdr_q      <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            wait_q     <= wait_d;
            row_q      <= row_d;
            col_q      <= col_d;
            m_q        <= m_d;
            n_q        <= n_d;
            mat_q      <= mat_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef MATRIX_OUT_HEADER_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_matrix_output.sv
// tb_matrix_output: scoreboard bench for matrix_output with a uart_tx busy model.
// Honours MATRIX_OUT_HEADER_EN the same way as the design.
module tb_matrix_output;
    localparam int MAX_DIM  = 5;
    localparam int ELEM_W   = 4;
    localparam int DW       = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int BYTE_CYC = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    mat_m = 4'd0;
    logic [3:0]    mat_n = 4'd0;
    logic [DW-1:0] mat_data = '0;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;
    logic          done;
    logic          err;

    logic          hold_busy = 1'b0;
    int            busy_cnt = 0;
    logic [7:0]    sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            txs_cnt = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    logic [7:0]    last_byte = 8'h00;

    matrix_output #(.MAX_DIM(MAX_DIM), .ELEM_W(ELEM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mat_m(mat_m), .mat_n(mat_n),
        .mat_data(mat_data), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy from the cycle after tx_start for BYTE_CYC cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= BYTE_CYC;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || hold_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_hex(input logic [3:0] v);
        if (v <= 4'd9) return 8'h30 + 8'(v);
        return 8'h41 + 8'(v - 4'd10);
    endfunction

    function automatic int frame_len(input int m, input int n);
        int l;
        l = m * (2 * n + 1);
`ifdef MATRIX_OUT_HEADER_EN
        l = l + 5;
`endif
        return l;
    endfunction

    function automatic logic [DW-1:0] put(input logic [DW-1:0] d, input int i, input int j,
                                          input logic [3:0] v);
        logic [DW-1:0] r;
        r = d;
        r[(i * MAX_DIM + j) * ELEM_W +: ELEM_W] = v;
        return r;
    endfunction

    task automatic push_frame(input int m, input int n, input logic [DW-1:0] d);
`ifdef MATRIX_OUT_HEADER_EN
        sb.push_back(exp_hex(4'(m)));
        sb.push_back(8'h78);
        sb.push_back(exp_hex(4'(n)));
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
`endif
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                sb.push_back(exp_hex(d[(i * MAX_DIM + j) * ELEM_W +: ELEM_W]));
                if (j != n - 1) sb.push_back(8'h20);
            end
            sb.push_back(8'h0D);
            sb.push_back(8'h0A);
        end
    endtask

    // Byte monitor: pops the scoreboard on each tx_start, checks hold and handshake.
    always @(negedge clk) begin
        if (rst) begin
            last_byte = 8'h00;
        end else begin
            if (tx_start) begin
                txs_cnt++;
                check("busy_low_at_tx_start", {31'd0, tx_busy}, 32'd0);
                check("sb_has_byte", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) check("byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
                last_byte = tx_data;
            end else begin
                check("tx_data_hold", {24'd0, tx_data}, {24'd0, last_byte});
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic wait_done(input string tag);
        for (int k = 0; k < 4000 && done !== 1'b1; k++) @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic start_frame(input int m, input int n, input logic [DW-1:0] d);
        @(negedge clk);
        mat_m = 4'(m);
        mat_n = 4'(n);
        mat_data = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mat_m = 4'd5;
        mat_n = 4'd5;
        mat_data = ~d;
    endtask

    task automatic run_frame(input string tag, input int m, input int n, input logic [DW-1:0] d);
        int c0;
        c0 = txs_cnt;
        push_frame(m, n, d);
        start_frame(m, n, d);
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        wait_done(tag);
        check({tag, "_nbytes"}, txs_cnt - c0, frame_len(m, n));
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic bad_frame(input string tag, input int m, input int n);
        int c0;
        c0 = txs_cnt;
        start_frame(m, n, '1);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check({tag, "_no_bytes"}, txs_cnt - c0, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int c0;
        int h0;
        int tgt;
        repeat (3) @(negedge clk);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        d = '0;
        d = put(d, 0, 0, 4'd1); d = put(d, 0, 1, 4'd2);
        d = put(d, 1, 0, 4'd3); d = put(d, 1, 1, 4'd4);
        run_frame("m2x2", 2, 2, d);

        d = '0;
        d = put(d, 0, 0, 4'hF);
        run_frame("m1x1", 1, 1, d);

        d = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 5; j++) d = put(d, i, j, 4'(10 + j));
        run_frame("m3x5", 3, 5, d);

        bad_frame("bad_m0", 0, 2);
        bad_frame("bad_m6", 6, 1);

        // tx_busy stuck high after the first byte; a mid-frame start must be ignored.
        d = '0;
        d = put(d, 0, 0, 4'd7); d = put(d, 0, 1, 4'd8); d = put(d, 0, 2, 4'd9);
        d = put(d, 1, 0, 4'd0); d = put(d, 1, 1, 4'd5); d = put(d, 1, 2, 4'hC);
        c0 = txs_cnt;
        push_frame(2, 3, d);
        start_frame(2, 3, d);
        for (int k = 0; k < 200 && tx_start !== 1'b1; k++) @(negedge clk);
        check("hold_first_byte", {31'd0, tx_start}, 32'd1);
        @(negedge clk);
        hold_busy = 1'b1;
        h0 = txs_cnt;
        for (int k = 0; k < 50; k++) begin
            if (k == 20) begin
                mat_m = 4'd1;
                mat_n = 4'd1;
                mat_data = '1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("hold_no_tx", txs_cnt - h0, 32'd0);
        check("hold_still_busy", {31'd0, busy}, 32'd1);
        hold_busy = 1'b0;
        wait_done("hold");
        check("hold_nbytes", txs_cnt - c0, frame_len(2, 3));
        check("hold_sb_empty", sb.size(), 32'd0);

        // Reset during row 1 of a 3x3 frame, then a full clean frame.
        d = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) d = put(d, i, j, 4'(i * 3 + j + 1));
        c0 = txs_cnt;
        tgt = frame_len(1, 3) + 2;
        push_frame(3, 3, d);
        start_frame(3, 3, d);
        for (int k = 0; k < 2000 && (txs_cnt - c0) < tgt; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("m3x3", 3, 3, d);

        repeat (5) @(negedge clk);
        check("total_done", done_cnt, 32'd7);
        check("total_err", err_cnt, 32'd2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
